// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA core arbiter.
package sha_pkg;

  localparam int BLOCK_W         = 512;
  localparam int HASH_W          = 256;
  localparam int DEFAULT_TIMEOUT = 200;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t LAUNCH = 2'd1;
  localparam state_t BUSY   = 2'd2;
  localparam state_t DONE   = 2'd3;

endpackage

// File: rtl/sha_rr_arb2.sv
// Two-way round-robin selector; 'last' is the index of the requester served most recently.
module sha_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sha_arbiter.sv
// Shares one sha_core between two requesters with round-robin arbitration.
// Optional BUSY-state watchdog enabled by defining SHA_ARB_TIMEOUT_EN.
module sha_arbiter
  import sha_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               req0,
  input  logic               req1,
  input  logic [BLOCK_W-1:0] block0,
  input  logic [BLOCK_W-1:0] block1,
  output logic [1:0]         gnt,
  output logic [1:0]         done,
  output logic               err,
  output logic [HASH_W-1:0]  hash,
  output logic               core_start,
  output logic [BLOCK_W-1:0] core_msg,
  input  logic               core_valid,
  input  logic [HASH_W-1:0]  core_hash
);

  state_t     state;
  logic       last;
  logic [1:0] win;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("sha_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  sha_rr_arb2 u_arb (
    .req   ({req1, req0}),
    .last  (last),
    .grant (win)
  );

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             expired;
  logic             err_q;

  // Fires on the last permitted BUSY cycle so DONE follows exactly TIMEOUT_CYCLES BUSY cycles.
  assign expired = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      done       <= 2'b00;
      core_start <= 1'b0;
      core_msg   <= '0;
      hash       <= '0;
      last       <= 1'b1;
`ifdef SHA_ARB_TIMEOUT_EN
      busy_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      done       <= 2'b00;
`ifdef SHA_ARB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win != 2'b00) begin
            gnt        <= win;
            core_msg   <= win[1] ? block1 : block0;
            core_start <= 1'b1;
            last       <= win[1];
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= BUSY;
`ifdef SHA_ARB_TIMEOUT_EN
          busy_cnt <= '0;
`endif
        end
        BUSY: begin
          if (core_valid) begin
            hash  <= core_hash;
            done  <= gnt;
            state <= DONE;
          end
`ifdef SHA_ARB_TIMEOUT_EN
          else if (expired) begin
            hash  <= '0;
            done  <= gnt;
            err_q <= 1'b1;
            state <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          gnt      <= 2'b00;
          core_msg <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_arbiter.sv
// Self-checking bench for sha_arbiter with a behavioural stand-in for sha_core.
// Define SHA_ARB_TIMEOUT_EN to exercise the watchdog with TIMEOUT_CYCLES=10.
module tb_sha_arbiter;

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 200;
`endif

  localparam logic [511:0] ABC_BLOCK = {32'h61626380, 416'h0, 64'h18};
  localparam logic [255:0] ABC_HASH  =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic         clk = 1'b0;
  logic         clr, req0, req1;
  logic [511:0] block0, block1;
  logic [1:0]   gnt, done;
  logic         err;
  logic [255:0] hash;
  logic         core_start;
  logic [511:0] core_msg;
  logic         core_valid;
  logic [255:0] core_hash;

  int pass_count  = 0;
  int check_count = 0;

  int   core_lat  = 2;
  logic core_hold = 1'b0;
  logic core_busy;
  int   core_cnt;

  int   start_count = 0;
  int   done_count  = 0;
  logic gnt11_seen  = 1'b0;
  logic err_seen    = 1'b0;

  // Reference arbitration state: index of the requester served most recently.
  int last_served = 1;

  sha_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .clr        (clr),
    .req0       (req0),
    .req1       (req1),
    .block0     (block0),
    .block1     (block1),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .hash       (hash),
    .core_start (core_start),
    .core_msg   (core_msg),
    .core_valid (core_valid),
    .core_hash  (core_hash)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] ref_hash(input logic [511:0] m);
    if (m == ABC_BLOCK) return ABC_HASH;
    return m[511:256] ^ {m[127:0], m[255:128]};
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Round-robin reference: returns winner index 0/1 and records it as last served.
  function automatic int model_pick(input logic r0, input logic r1);
    int w;
    if (r0 && r1) w = 1 - last_served;
    else          w = r1 ? 1 : 0;
    last_served = w;
    return w;
  endfunction

  function automatic logic [1:0] onehot(input int w);
    return (w == 0) ? 2'b01 : 2'b10;
  endfunction

  // Stand-in sha_core: result appears core_lat cycles after the start pulse.
  always @(posedge clk) begin
    if (clr) begin
      core_busy  <= 1'b0;
      core_valid <= 1'b0;
      core_hash  <= '0;
      core_cnt   <= 0;
    end else begin
      core_valid <= 1'b0;
      if (core_start) begin
        core_busy <= 1'b1;
        core_cnt  <= core_lat;
        core_hash <= ref_hash(core_msg);
      end else if (core_busy && !core_hold) begin
        if (core_cnt <= 1) begin
          core_valid <= 1'b1;
          core_busy  <= 1'b0;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (core_start)    start_count++;
    if (done != 2'b00) done_count++;
    if (gnt == 2'b11)  gnt11_seen = 1'b1;
    if (err)           err_seen   = 1'b1;
  end

  task automatic wait_done(input logic [1:0] drop_mask, output logic [1:0] d,
                           output logic [255:0] h, output logic e, output int cycles);
    d = 2'b00; h = '0; e = 1'b0; cycles = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (gnt[0] && drop_mask[0]) req0 = 1'b0;
      if (gnt[1] && drop_mask[1]) req1 = 1'b0;
      if (done != 2'b00) begin
        d = done; h = hash; e = err; cycles = i;
        break;
      end
    end
    if (cycles < 0) $display("[TB] note: no done pulse within 300 cycles");
  endtask

  task automatic do_reset();
    clr = 1'b1; req0 = 1'b0; req1 = 1'b0; core_hold = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    last_served = 1;
  endtask

  task automatic test_reset();
    do_reset();
    check_count++; if (gnt !== 2'b00) $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); else pass_count++;
    check_count++; if (done !== 2'b00) $display("[TB] FAIL reset_done: got %b expected 00", done); else pass_count++;
    check_count++; if (err !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err); else pass_count++;
    check_count++; if (core_start !== 1'b0) $display("[TB] FAIL reset_start: got %b expected 0", core_start); else pass_count++;
    check_count++; if (core_msg !== '0) $display("[TB] FAIL reset_msg: got %h expected 0", core_msg); else pass_count++;
    check_count++; if (hash !== '0) $display("[TB] FAIL reset_hash: got %h expected 0", hash); else pass_count++;
  endtask

  task automatic test_abc();
    logic [1:0] d; logic [255:0] h; logic e; int cyc; int s;
    core_lat = $urandom_range(1, 5);
    s = start_count;
    block0 = ABC_BLOCK; req0 = 1'b1;
    @(negedge clk);
    check_count++; if (gnt !== 2'b01) $display("[TB] FAIL abc_gnt: got %b expected 01", gnt); else pass_count++;
    check_count++; if (core_start !== 1'b1) $display("[TB] FAIL abc_start_on: got %b expected 1", core_start); else pass_count++;
    check_count++; if (core_msg !== ABC_BLOCK) $display("[TB] FAIL abc_msg: got %h expected %h", core_msg, ABC_BLOCK); else pass_count++;
    req0 = 1'b0;
    @(negedge clk);
    check_count++; if (core_start !== 1'b0) $display("[TB] FAIL abc_start_off: got %b expected 0", core_start); else pass_count++;
    wait_done(2'b00, d, h, e, cyc);
    void'(model_pick(1'b1, 1'b0));
    check_count++; if (d !== 2'b01) $display("[TB] FAIL abc_done: got %b expected 01", d); else pass_count++;
    check_count++; if (h !== ABC_HASH) $display("[TB] FAIL abc_hash: got %h expected %h", h, ABC_HASH); else pass_count++;
    check_count++; if (e !== 1'b0) $display("[TB] FAIL abc_err: got %b expected 0", e); else pass_count++;
    check_count++; if (cyc + 2 != core_lat + 3) $display("[TB] FAIL abc_latency: got %0d expected %0d", cyc + 2, core_lat + 3); else pass_count++;
    repeat (2) @(negedge clk);
    check_count++; if (gnt !== 2'b00) $display("[TB] FAIL abc_gnt_clear: got %b expected 00", gnt); else pass_count++;
    check_count++; if (hash !== ABC_HASH) $display("[TB] FAIL abc_hash_hold: got %h expected %h", hash, ABC_HASH); else pass_count++;
    check_count++; if (start_count - s != 1) $display("[TB] FAIL abc_start_count: got %0d expected 1", start_count - s); else pass_count++;
  endtask

  task automatic test_tie();
    logic [1:0] d; logic [255:0] h; logic e; int cyc; int s; int w;
    logic [511:0] b0, b1;
    do_reset();
    core_lat = $urandom_range(1, 6);
    b0 = rand_block(); b1 = rand_block();
    block0 = b0; block1 = b1;
    gnt11_seen = 1'b0;
    s = done_count;
    req0 = 1'b1; req1 = 1'b1;
    w = model_pick(1'b1, 1'b1);
    wait_done(2'b11, d, h, e, cyc);
    check_count++; if (d !== onehot(w)) $display("[TB] FAIL tie_first: got %b expected %b", d, onehot(w)); else pass_count++;
    check_count++; if (h !== ref_hash(w ? b1 : b0)) $display("[TB] FAIL tie_first_hash: got %h expected %h", h, ref_hash(w ? b1 : b0)); else pass_count++;
    w = model_pick(1'b0, 1'b1);
    wait_done(2'b11, d, h, e, cyc);
    check_count++; if (d !== onehot(w)) $display("[TB] FAIL tie_second: got %b expected %b", d, onehot(w)); else pass_count++;
    check_count++; if (h !== ref_hash(w ? b1 : b0)) $display("[TB] FAIL tie_second_hash: got %h expected %h", h, ref_hash(w ? b1 : b0)); else pass_count++;
    repeat (3) @(negedge clk);
    check_count++; if (done_count - s != 2) $display("[TB] FAIL tie_done_count: got %0d expected 2", done_count - s); else pass_count++;
    check_count++; if (gnt11_seen !== 1'b0) $display("[TB] FAIL tie_gnt11: got %b expected 0", gnt11_seen); else pass_count++;
  endtask

  task automatic test_alternate();
    logic [1:0] d; logic [255:0] h; logic e; int cyc; int w;
    logic [511:0] b0, b1;
    b0 = rand_block(); b1 = rand_block();
    block0 = b0; block1 = b1;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_lat = $urandom_range(1, 6);
      w = model_pick(1'b1, 1'b1);
      wait_done(2'b00, d, h, e, cyc);
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      check_count++; if (d !== onehot(w)) $display("[TB] FAIL alt_grant_%0d: got %b expected %b", i, d, onehot(w)); else pass_count++;
      check_count++; if (h !== ref_hash(w ? b1 : b0)) $display("[TB] FAIL alt_hash_%0d: got %h expected %h", i, h, ref_hash(w ? b1 : b0)); else pass_count++;
    end
    repeat (4) @(negedge clk);
    check_count++; if (gnt !== 2'b00) $display("[TB] FAIL alt_idle: got %b expected 00", gnt); else pass_count++;
  endtask

  task automatic test_drop();
    logic [1:0] d; logic [255:0] h; logic e; int cyc; int s; int w;
    logic [511:0] b1;
    core_lat = 4;
    b1 = rand_block(); block1 = b1;
    s = done_count;
    req1 = 1'b1;
    w = model_pick(1'b0, 1'b1);
    @(negedge clk);
    check_count++; if (gnt !== 2'b10) $display("[TB] FAIL drop_gnt: got %b expected 10", gnt); else pass_count++;
    @(negedge clk);
    req1 = 1'b0;
    wait_done(2'b00, d, h, e, cyc);
    check_count++; if (d !== onehot(w)) $display("[TB] FAIL drop_done: got %b expected %b", d, onehot(w)); else pass_count++;
    check_count++; if (h !== ref_hash(b1)) $display("[TB] FAIL drop_hash: got %h expected %h", h, ref_hash(b1)); else pass_count++;
    repeat (4) @(negedge clk);
    check_count++; if (done_count - s != 1) $display("[TB] FAIL drop_done_count: got %0d expected 1", done_count - s); else pass_count++;
    check_count++; if (gnt !== 2'b00) $display("[TB] FAIL drop_gnt_clear: got %b expected 00", gnt); else pass_count++;
  endtask

  task automatic test_reset_busy();
    logic [1:0] d; logic [255:0] h; logic e; int cyc; int s; int w;
    logic [511:0] b0;
    core_lat = 8;
    block0 = rand_block(); req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    s = done_count;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    last_served = 1;
    check_count++; if (gnt !== 2'b00) $display("[TB] FAIL rb_gnt: got %b expected 00", gnt); else pass_count++;
    check_count++; if (done !== 2'b00) $display("[TB] FAIL rb_done: got %b expected 00", done); else pass_count++;
    check_count++; if (err !== 1'b0) $display("[TB] FAIL rb_err: got %b expected 0", err); else pass_count++;
    check_count++; if (core_start !== 1'b0) $display("[TB] FAIL rb_start: got %b expected 0", core_start); else pass_count++;
    check_count++; if (core_msg !== '0) $display("[TB] FAIL rb_msg: got %h expected 0", core_msg); else pass_count++;
    check_count++; if (hash !== '0) $display("[TB] FAIL rb_hash: got %h expected 0", hash); else pass_count++;
    repeat (12) @(negedge clk);
    check_count++; if (done_count - s != 0) $display("[TB] FAIL rb_no_done: got %0d expected 0", done_count - s); else pass_count++;
    core_lat = $urandom_range(1, 6);
    b0 = rand_block(); block0 = b0;
    req0 = 1'b1;
    w = model_pick(1'b1, 1'b0);
    wait_done(2'b01, d, h, e, cyc);
    check_count++; if (d !== onehot(w)) $display("[TB] FAIL rb_after_done: got %b expected %b", d, onehot(w)); else pass_count++;
    check_count++; if (h !== ref_hash(b0)) $display("[TB] FAIL rb_after_hash: got %h expected %h", h, ref_hash(b0)); else pass_count++;
    check_count++; if (e !== 1'b0) $display("[TB] FAIL rb_after_err: got %b expected 0", e); else pass_count++;
  endtask

`ifdef SHA_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] d; logic [255:0] h; logic e; int cyc;
    do_reset();
    core_hold = 1'b1;
    block0 = rand_block(); req0 = 1'b1;
    wait_done(2'b01, d, h, e, cyc);
    check_count++; if (d !== 2'b01) $display("[TB] FAIL to_done: got %b expected 01", d); else pass_count++;
    check_count++; if (e !== 1'b1) $display("[TB] FAIL to_err: got %b expected 1", e); else pass_count++;
    check_count++; if (h !== '0) $display("[TB] FAIL to_hash: got %h expected 0", h); else pass_count++;
    check_count++; if (cyc != TO + 2) $display("[TB] FAIL to_latency: got %0d expected %0d", cyc, TO + 2); else pass_count++;
    @(negedge clk);
    check_count++; if (err !== 1'b0) $display("[TB] FAIL to_err_pulse: got %b expected 0", err); else pass_count++;
    do_reset();
  endtask
`else
  task automatic test_err_tied();
    check_count++; if (err_seen !== 1'b0) $display("[TB] FAIL err_tied: got %b expected 0", err_seen); else pass_count++;
  endtask
`endif

  initial begin
    clr = 1'b1; req0 = 1'b0; req1 = 1'b0;
    block0 = '0; block1 = '0;
    test_reset();
    test_abc();
    test_tie();
    test_alternate();
    test_drop();
    test_reset_busy();
`ifdef SHA_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_err_tied();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sha_arbiter.md
SHA_ARBITER -- requirements
Module: sha_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 200, meaning the maximum number of BUSY cycles before abort (used only with SHA_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: requester k asks for one 512-bit hash.
REQ-005 The block SHALL have ports block0 and block1, input, 512 bits each: the padded message of requester k, held stable while reqk is high.
REQ-006 The block SHALL have port gnt, output, 2 bits: one-hot owner of the core, 00 when idle.
REQ-007 The block SHALL have port done, output, 2 bits: one-cycle pulse to the owner when its result is ready.
REQ-008 The block SHALL have port err, output, 1 bit: pulses with done on timeout abort; constant 0 without SHA_ARB_TIMEOUT_EN.
REQ-009 The block SHALL have port hash, output, 256 bits: the latched result, valid in the done cycle and held until the next done.
REQ-010 The block SHALL have port core_start, output, 1 bit: drives the start input of sha_core.
REQ-011 The block SHALL have port core_msg, output, 512 bits: drives the message input of sha_core.
REQ-012 The block SHALL have port core_valid, input, 1 bit: the valid output of sha_core.
REQ-013 The block SHALL have port core_hash, input, 256 bits: the hashvalue output of sha_core.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, LAUNCH, BUSY and DONE.
REQ-015 IDLE: if any req is high, the block SHALL pick the winner, set gnt and go to LAUNCH on the next edge.
REQ-016 Arbitration SHALL be round-robin: with both req high, the winner is the requester not served last; a single req wins immediately; the last-served pointer resets to 1, so req0 wins the first tie.
REQ-017 LAUNCH: core_start SHALL be 1 for exactly this one cycle, core_msg SHALL equal the winner's block, and the next state SHALL be BUSY.
REQ-018 core_msg SHALL be registered at the IDLE->LAUNCH edge and held until the FSM leaves DONE.
REQ-019 BUSY: the first cycle with core_valid=1 SHALL latch core_hash into hash and move to DONE.
REQ-020 core_valid SHALL be ignored in IDLE, LAUNCH and DONE.
REQ-021 DONE: done[owner] SHALL be 1 for one cycle, gnt SHALL clear on exit, and the next state SHALL be IDLE.
REQ-022 Minimum request-to-done latency SHALL be core latency + 3 cycles.
REQ-023 A req dropped mid-operation SHALL be ignored: the operation completes and done is still pulsed.
REQ-024 A req still high in DONE SHALL count as a new request, arbitrated in the following IDLE cycle.
REQ-025 The owner's block SHALL not be resampled during an operation.

Reset
REQ-026 With clr=1 at an edge, from any state, the block SHALL go to IDLE and clear gnt, done, err, core_start, core_msg, hash and the timeout counter, and set the pointer to 1.
REQ-027 A reset mid-operation SHALL discard the operation without a done pulse; the integrator resets sha_core with the same clr.

Configuration
REQ-028 With SHA_ARB_TIMEOUT_EN defined, a cycle counter SHALL run in BUSY; on reaching TIMEOUT_CYCLES without core_valid, the block SHALL go to DONE with done[owner]=1, err=1 and hash cleared to 0.
REQ-029 Without SHA_ARB_TIMEOUT_EN, there SHALL be no counter, BUSY SHALL wait indefinitely, and err SHALL be tied to 0.

Structure
REQ-030 Package sha_pkg SHALL hold the state typedef, the constants for block width 512 and hash width 256, and the default timeout.
REQ-031 Round-robin selection SHALL be a sub-module sha_rr_arb2 (inputs req[1:0] and last; output one-hot grant; combinational).

Verification
REQ-032 Bench SHALL apply req0 with block0 = padded "abc" (61626380_0..._00000018) -> gnt=01, core_start pulse 1 cycle, done=01, hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-033 Bench SHALL raise req0 and req1 in the same cycle after reset -> req0 served first, then req1; two done pulses; gnt never 11.
REQ-034 Bench SHALL hold both req high for 4 operations -> grants alternate 01,10,01,10.
REQ-035 Bench SHALL drop req1 one cycle after LAUNCH -> operation completes, done=10 pulses once.
REQ-036 Bench SHALL assert clr during BUSY -> next cycle all outputs 0, no done pulse, and a new req0 is served normally.
REQ-037 With SHA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, bench SHALL hold core_valid low -> done=owner and err=1 after 10 BUSY cycles, hash=0.
